// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : hazard_pkg                                                     |
// | Brief   : Shared types and constants for the pipeline hazard controller. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package hazard_pkg;

   localparam int c_REG_IDX_W = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_WB  = 2'd1,
      FWD_MEM = 2'd2
   } fwd_sel_e;

   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_controller_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipeline_hazard_controller_if                                  |
// | Brief   : Pipeline-status inputs and hazard-control outputs bundle.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface pipeline_hazard_controller_if
   import hazard_pkg::*;
   ();

   logic [c_REG_IDX_W-1:0] id_rs1;
   logic [c_REG_IDX_W-1:0] id_rs2;
   logic [c_REG_IDX_W-1:0] ex_rs1;
   logic [c_REG_IDX_W-1:0] ex_rs2;
   logic [c_REG_IDX_W-1:0] ex_rd;
   logic                   ex_mem_read;
   logic [c_REG_IDX_W-1:0] mem_rd;
   logic                   mem_reg_write;
   logic [c_REG_IDX_W-1:0] wb_rd;
   logic                   wb_reg_write;
   logic                   pc_src;
   logic                   dmem_req;
   logic                   dmem_ack;
   logic                   cnt_clear;

   logic [1:0]             r1_solve;
   logic [1:0]             r2_solve;
   logic                   en_fetch;
   logic                   en_decode;
   logic                   en_execute;
   logic                   en_mem;
   logic                   en_wb;
   logic                   flush_decode;
   logic                   flush_execute;
   logic                   mem_error;

   // Core side: reports pipeline status, consumes hazard controls.
   modport master (
      output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             pc_src, dmem_req, dmem_ack, cnt_clear,
      input  r1_solve, r2_solve, en_fetch, en_decode, en_execute, en_mem, en_wb,
             flush_decode, flush_execute, mem_error
   );

   // Controller side.
   modport slave (
      input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_mem_read,
             mem_rd, mem_reg_write, wb_rd, wb_reg_write,
             pc_src, dmem_req, dmem_ack, cnt_clear,
      output r1_solve, r2_solve, en_fetch, en_decode, en_execute, en_mem, en_wb,
             flush_decode, flush_execute, mem_error
   );

endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_controller_forward_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : forward_unit                                                   |
// | Brief   : Per-operand forwarding select; memory stage beats writeback.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module forward_unit
   import hazard_pkg::*;
(
   input  logic [c_REG_IDX_W-1:0] rs,
   input  logic [c_REG_IDX_W-1:0] mem_rd,
   input  logic                   mem_reg_write,
   input  logic [c_REG_IDX_W-1:0] wb_rd,
   input  logic                   wb_reg_write,
   output fwd_sel_e               sel
);

   logic w_mem_hit;
   logic w_wb_hit;

   // x0 is hardwired to zero, so a write to it never produces a forward.
   assign w_mem_hit = mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
   assign w_wb_hit  = wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

   always_comb begin
      sel = FWD_REG;
      if (w_mem_hit) begin
         sel = FWD_MEM;
      end else if (w_wb_hit) begin
         sel = FWD_WB;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : pipeline_hazard_controller                                     |
// | Brief   : Forwarding, load-use stall, flush and memory-freeze control.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_hazard_controller
   import hazard_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 32
) (
   input  logic                               clk,
   input  logic                               reset,
   pipeline_hazard_controller_if.slave        bus,
   output logic [CNT_W-1:0]                   stall_cycles,
   output logic [CNT_W-1:0]                   flush_count
);

   localparam int                    c_WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [c_WAIT_W-1:0]   c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

   hz_state_e              r_state;
   hz_state_e              w_state_next;
   logic [c_WAIT_W-1:0]    r_wait_cnt;
   logic                   r_mem_error;
   logic [CNT_W-1:0]       r_stall_cycles;
   logic [CNT_W-1:0]       r_flush_count;

   logic                   w_load_use;
   logic                   w_wait_last;
   logic                   w_freeze_entry;
   logic                   w_wait_done;
   logic                   w_apply_run;
   logic                   w_en_front;
   logic                   w_en_back;
   logic                   w_flush_dec;
   logic                   w_flush_ex;
   logic                   w_any_stall;

   logic [c_REG_IDX_W-1:0] w_ex_rs [2];
   fwd_sel_e               w_sel   [2];

   // ------------------------------------------------------------------
   // Operand forwarding
   // ------------------------------------------------------------------
   assign w_ex_rs[0] = bus.ex_rs1;
   assign w_ex_rs[1] = bus.ex_rs2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         forward_unit u_forward_unit (
            .rs            (w_ex_rs[gi]),
            .mem_rd        (bus.mem_rd),
            .mem_reg_write (bus.mem_reg_write),
            .wb_rd         (bus.wb_rd),
            .wb_reg_write  (bus.wb_reg_write),
            .sel           (w_sel[gi])
         );
      end
   endgenerate

   assign bus.r1_solve = w_sel[0];
   assign bus.r2_solve = w_sel[1];

   // ------------------------------------------------------------------
   // Hazard conditions
   // ------------------------------------------------------------------
   assign w_load_use     = bus.ex_mem_read && (bus.ex_rd != '0) &&
                           ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));
   assign w_wait_last    = (r_wait_cnt == c_WAIT_LAST);
   assign w_freeze_entry = (r_state == RUN) && bus.dmem_req && !bus.dmem_ack;
   assign w_wait_done    = (r_state == MEM_WAIT) && (bus.dmem_ack || w_wait_last);

   // ------------------------------------------------------------------
   // Freeze FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ------------------------------------------------------------------
   // Freeze FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         RUN: begin
            if (w_freeze_entry) begin
               w_state_next = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (w_wait_done) begin
               w_state_next = RUN;
            end
         end
         default: w_state_next = RUN;
      endcase
   end

   // ------------------------------------------------------------------
   // Freeze FSM: enable / flush decode
   // ------------------------------------------------------------------
   always_comb begin
      w_apply_run = 1'b0;
      w_en_front  = 1'b1;
      w_en_back   = 1'b1;
      w_flush_dec = 1'b0;
      w_flush_ex  = 1'b0;
      if (!reset) begin
         case (r_state)
            RUN: begin
               if (w_freeze_entry) begin
                  w_en_front = 1'b0;
                  w_en_back  = 1'b0;
               end else begin
                  w_apply_run = 1'b1;
               end
            end
            MEM_WAIT: begin
               if (w_wait_done) begin
                  w_apply_run = 1'b1;
               end else begin
                  w_en_front = 1'b0;
                  w_en_back  = 1'b0;
               end
            end
            default: w_apply_run = 1'b1;
         endcase

         // A taken branch wins over load-use: the decode slot is wrong-path.
         if (w_apply_run) begin
            if (bus.pc_src) begin
               w_flush_dec = 1'b1;
               w_flush_ex  = 1'b1;
            end else if (w_load_use) begin
               w_en_front  = 1'b0;
               w_flush_ex  = 1'b1;
            end
         end
      end
   end

   assign bus.en_fetch      = w_en_front;
   assign bus.en_decode     = w_en_front;
   assign bus.en_execute    = w_en_back;
   assign bus.en_mem        = w_en_back;
   assign bus.en_wb         = w_en_back;
   assign bus.flush_decode  = w_flush_dec;
   assign bus.flush_execute = w_flush_ex;

   assign w_any_stall = !(w_en_front && w_en_back);

   // ------------------------------------------------------------------
   // Wait counter and sticky timeout error
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wait_cnt  <= '0;
         r_mem_error <= 1'b0;
      end else if (r_state == RUN) begin
         r_wait_cnt <= '0;
      end else if (!bus.dmem_ack) begin
         if (w_wait_last) begin
            r_mem_error <= 1'b1;
         end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
      end
   end

   assign bus.mem_error = r_mem_error;

   // ------------------------------------------------------------------
   // Saturating performance counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset || bus.cnt_clear) begin
         r_stall_cycles <= '0;
      end else if (w_any_stall && (r_stall_cycles != '1)) begin
         r_stall_cycles <= r_stall_cycles + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || bus.cnt_clear) begin
         r_flush_count <= '0;
      end else if (w_flush_dec && (r_flush_count != '1)) begin
         r_flush_count <= r_flush_count + 1'b1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_pipeline_hazard_controller                                  |
// | Brief   : Directed self-checking bench for the hazard controller.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipeline_hazard_controller;

   localparam int c_TIMEOUT = 4;
   localparam int c_CNT_W   = 4;

   logic               clk;
   logic               reset;
   logic [c_CNT_W-1:0] stall_cycles;
   logic [c_CNT_W-1:0] flush_count;
   int                 n_cmp;
   int                 n_err;

   pipeline_hazard_controller_if bus ();

   pipeline_hazard_controller #(
      .TIMEOUT (c_TIMEOUT),
      .CNT_W   (c_CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );

   logic [4:0] w_en;
   logic [1:0] w_fl;
   assign w_en = {bus.en_fetch, bus.en_decode, bus.en_execute, bus.en_mem, bus.en_wb};
   assign w_fl = {bus.flush_decode, bus.flush_execute};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0;
      bus.ex_rd = '0; bus.ex_mem_read = 1'b0;
      bus.mem_rd = '0; bus.mem_reg_write = 1'b0;
      bus.wb_rd = '0; bus.wb_reg_write = 1'b0;
      bus.pc_src = 1'b0; bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
      bus.cnt_clear = 1'b0;
   endtask

   task automatic clear_counters();
      bus.cnt_clear = 1'b1;
      tick();
      bus.cnt_clear = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      bus.pc_src = 1'b1; bus.dmem_req = 1'b1;
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
      tick();
      tick();
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL reset_en: got %b want 11111", w_en); end
      n_cmp++; if (w_fl !== 2'b00) begin n_err++; $display("FAIL reset_flush: got %b want 00", w_fl); end
      n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL reset_stall: got %0d want 0", stall_cycles); end
      n_cmp++; if (flush_count !== 4'd0) begin n_err++; $display("FAIL reset_flushcnt: got %0d want 0", flush_count); end
      n_cmp++; if (bus.mem_error !== 1'b0) begin n_err++; $display("FAIL reset_memerr: got %b want 0", bus.mem_error); end
      idle_inputs();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_forwarding();
      bus.ex_rs1 = 5'd5; bus.ex_rs2 = 5'd9;
      bus.mem_rd = 5'd5; bus.wb_rd = 5'd5;
      bus.mem_reg_write = 1'b1; bus.wb_reg_write = 1'b1;
      #1;
      n_cmp++; if (bus.r1_solve !== 2'd2) begin n_err++; $display("FAIL fwd_mem_prio: got %0d want 2", bus.r1_solve); end
      n_cmp++; if (bus.r2_solve !== 2'd0) begin n_err++; $display("FAIL fwd_r2_nomatch: got %0d want 0", bus.r2_solve); end
      bus.mem_rd = 5'd0;
      #1;
      n_cmp++; if (bus.r1_solve !== 2'd1) begin n_err++; $display("FAIL fwd_wb: got %0d want 1", bus.r1_solve); end
      bus.mem_rd = 5'd5; bus.mem_reg_write = 1'b0;
      bus.ex_rs2 = 5'd5;
      #1;
      n_cmp++; if (bus.r1_solve !== 2'd1) begin n_err++; $display("FAIL fwd_mem_we_off: got %0d want 1", bus.r1_solve); end
      n_cmp++; if (bus.r2_solve !== 2'd1) begin n_err++; $display("FAIL fwd_r2_wb: got %0d want 1", bus.r2_solve); end
      bus.mem_reg_write = 1'b1; bus.wb_rd = 5'd12; bus.ex_rs2 = 5'd12;
      #1;
      n_cmp++; if (bus.r2_solve !== 2'd1) begin n_err++; $display("FAIL fwd_r2_wb12: got %0d want 1", bus.r2_solve); end
      bus.ex_rs1 = 5'd0; bus.mem_rd = 5'd0; bus.wb_rd = 5'd0;
      #1;
      n_cmp++; if (bus.r1_solve !== 2'd0) begin n_err++; $display("FAIL fwd_x0: got %0d want 0", bus.r1_solve); end
      idle_inputs();
      tick();
   endtask

   task automatic test_load_use();
      clear_counters();
      n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL lu_clear: got %0d want 0", stall_cycles); end
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7;
      #1;
      n_cmp++; if (w_en !== 5'b00111) begin n_err++; $display("FAIL lu_en: got %b want 00111", w_en); end
      n_cmp++; if (w_fl !== 2'b01) begin n_err++; $display("FAIL lu_flush: got %b want 01", w_fl); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL lu_stallcnt: got %0d want 1", stall_cycles); end
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL lu_x0: got %b want 11111", w_en); end
      bus.ex_mem_read = 1'b0; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL lu_noload: got %b want 11111", w_en); end
      idle_inputs();
      tick();
   endtask

   task automatic test_branch_vs_load_use();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs1 = 5'd7;
      bus.pc_src = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL br_en: got %b want 11111", w_en); end
      n_cmp++; if (w_fl !== 2'b11) begin n_err++; $display("FAIL br_flush: got %b want 11", w_fl); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (flush_count !== 4'd1) begin n_err++; $display("FAIL br_flushcnt: got %0d want 1", flush_count); end
      n_cmp++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL br_stallcnt: got %0d want 1", stall_cycles); end
      tick();
   endtask

   task automatic test_mem_freeze();
      clear_counters();
      bus.dmem_req = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b00000) begin n_err++; $display("FAIL frz_req_en: got %b want 00000", w_en); end
      n_cmp++; if (w_fl !== 2'b00) begin n_err++; $display("FAIL frz_req_flush: got %b want 00", w_fl); end
      tick();
      bus.pc_src = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b00000) begin n_err++; $display("FAIL frz_w0_en: got %b want 00000", w_en); end
      n_cmp++; if (w_fl !== 2'b00) begin n_err++; $display("FAIL frz_w0_pcsrc: got %b want 00", w_fl); end
      tick();
      bus.pc_src = 1'b0;
      #1;
      n_cmp++; if (w_en !== 5'b00000) begin n_err++; $display("FAIL frz_w1_en: got %b want 00000", w_en); end
      tick();
      bus.dmem_ack = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL frz_ack_en: got %b want 11111", w_en); end
      tick();
      bus.dmem_req = 1'b0; bus.dmem_ack = 1'b0;
      #1;
      n_cmp++; if (stall_cycles !== 4'd3) begin n_err++; $display("FAIL frz_stallcnt: got %0d want 3", stall_cycles); end
      n_cmp++; if (flush_count !== 4'd0) begin n_err++; $display("FAIL frz_flushcnt: got %0d want 0", flush_count); end
      bus.dmem_req = 1'b1; bus.dmem_ack = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL frz_1cyc_en: got %b want 11111", w_en); end
      tick();
      idle_inputs();
      #1;
      n_cmp++; if (stall_cycles !== 4'd3) begin n_err++; $display("FAIL frz_1cyc_cnt: got %0d want 3", stall_cycles); end
      tick();
   endtask

   task automatic test_timeout();
      clear_counters();
      bus.dmem_req = 1'b1;
      tick();
      tick();
      tick();
      #1;
      n_cmp++; if (w_en !== 5'b00000) begin n_err++; $display("FAIL to_w2_en: got %b want 00000", w_en); end
      n_cmp++; if (bus.mem_error !== 1'b0) begin n_err++; $display("FAIL to_early_err: got %b want 0", bus.mem_error); end
      tick();
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL to_last_en: got %b want 11111", w_en); end
      n_cmp++; if (bus.mem_error !== 1'b0) begin n_err++; $display("FAIL to_last_err: got %b want 0", bus.mem_error); end
      tick();
      bus.dmem_req = 1'b0;
      #1;
      n_cmp++; if (bus.mem_error !== 1'b1) begin n_err++; $display("FAIL to_err_set: got %b want 1", bus.mem_error); end
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL to_back_run: got %b want 11111", w_en); end
      n_cmp++; if (stall_cycles !== 4'd4) begin n_err++; $display("FAIL to_stallcnt: got %0d want 4", stall_cycles); end
      tick();
      tick();
      tick();
      n_cmp++; if (bus.mem_error !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b want 1", bus.mem_error); end
   endtask

   task automatic test_reset_in_wait();
      bus.dmem_req = 1'b1;
      tick();
      reset = 1'b1;
      #1;
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL rw_en_forced: got %b want 11111", w_en); end
      tick();
      reset = 1'b0;
      bus.dmem_req = 1'b0;
      #1;
      n_cmp++; if (bus.mem_error !== 1'b0) begin n_err++; $display("FAIL rw_err_cleared: got %b want 0", bus.mem_error); end
      n_cmp++; if (w_en !== 5'b11111) begin n_err++; $display("FAIL rw_state_run: got %b want 11111", w_en); end
      n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL rw_stallcnt: got %0d want 0", stall_cycles); end
      tick();
   endtask

   task automatic test_saturation();
      clear_counters();
      bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd4; bus.id_rs1 = 5'd4;
      for (int i = 0; i < 20; i++) tick();
      n_cmp++; if (stall_cycles !== 4'd15) begin n_err++; $display("FAIL sat_stall: got %0d want 15", stall_cycles); end
      bus.cnt_clear = 1'b1;
      tick();
      bus.cnt_clear = 1'b0;
      idle_inputs();
      #1;
      n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL sat_clear_prio: got %0d want 0", stall_cycles); end
      bus.pc_src = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      bus.pc_src = 1'b0;
      #1;
      n_cmp++; if (flush_count !== 4'd15) begin n_err++; $display("FAIL sat_flush: got %0d want 15", flush_count); end
      n_cmp++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL sat_flush_nostall: got %0d want 0", stall_cycles); end
      clear_counters();
      #1;
      n_cmp++; if (flush_count !== 4'd0) begin n_err++; $display("FAIL sat_flush_clear: got %0d want 0", flush_count); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_vs_load_use();
      test_mem_freeze();
      test_timeout();
      test_reset_in_wait();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central hazard controller for the five-stage pipelined RV32 core. It generates the execute-stage operand-forwarding selects, load-use stalls and branch/jump flushes. It also contains a freeze FSM that holds the entire pipeline while a multi-cycle data-memory access completes, with a timeout. Saturating stall and flush counters are exposed for performance monitoring.

## Interface
- `TIMEOUT`, default 64: maximum number of MEM_WAIT cycles before the access is abandoned.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in decode.
- `ex_rs1`, `ex_rs2` in 5 each: source registers of the instruction in execute.
- `ex_rd` in 5: destination register of the instruction in execute.
- `ex_mem_read` in 1: the execute-stage instruction is a load.
- `mem_rd` in 5, `mem_reg_write` in 1: destination and write-enable of the memory stage (ALU result path).
- `wb_rd` in 5, `wb_reg_write` in 1: destination and write-enable of the writeback stage (read-data path).
- `pc_src` in 1: branch taken or jump, from execute.
- `dmem_req` in 1: the memory stage is issuing a data access this cycle.
- `dmem_ack` in 1: the data access completes this cycle.
- `cnt_clear` in 1: synchronous clear of both counters.
- `r1_solve`, `r2_solve` out 2 each: forwarding selects. 0 selects the register file, 1 the writeback read data, 2 the memory-stage ALU result.
- `en_fetch`, `en_decode`, `en_execute`, `en_mem`, `en_wb` out 1 each: pipeline-register enables.
- `flush_decode`, `flush_execute` out 1 each: load a bubble into the decode/execute register.
- `mem_error` out 1: sticky; set on timeout.
- `stall_cycles`, `flush_count` out CNT_W each: saturating performance counters.

## Operation
- **Forwarding (per operand, combinational):**
  - Select 2 if `mem_reg_write` is set, `mem_rd` is non-zero and `mem_rd` equals `ex_rsN`.
  - Otherwise select 1 if `wb_reg_write` is set, `wb_rd` is non-zero and `wb_rd` equals `ex_rsN`.
  - Otherwise select 0. The memory stage has priority over writeback.
- **Load-use condition:** `ex_mem_read` is set, `ex_rd` is non-zero, and `ex_rd` equals `id_rs1` or `id_rs2`.
- **FSM states:** RUN and MEM_WAIT.
- **In RUN, evaluated in priority order:**
  1. `dmem_req` set and `dmem_ack` clear: every enable drops to 0, no flush, next state is MEM_WAIT, and `wait_cnt` is set to 0.
  2. `pc_src` set: all enables are 1, and `flush_decode` and `flush_execute` are both 1. A branch overrides a simultaneous load-use stall, because the decode instruction is on the wrong path.
  3. Load-use: `en_fetch` and `en_decode` are 0, all other enables are 1, and `flush_execute` is 1.
  4. Otherwise: all enables are 1 and both flushes are 0.
- **In MEM_WAIT:**
  - While waiting, all enables are 0 and both flushes are 0. `pc_src` and the load-use condition are ignored.
  - `dmem_ack` set: the RUN rules apply this cycle with step 1 suppressed, and next state is RUN.
  - `wait_cnt` equal to `TIMEOUT`-1 with no ack: `mem_error` is set to 1, the RUN rules apply with step 1 suppressed, and next state is RUN.
  - Otherwise `wait_cnt` increments.
- **`dmem_req` and `dmem_ack` together in RUN:** no freeze.
- **`stall_cycles`:** increments in every cycle where any enable is 0.
- **`flush_count`:** increments in every cycle where `flush_decode` is 1.
- **Counter rules:**
  - Both counters saturate at all-ones.
  - `cnt_clear` takes priority over incrementing.
  - `mem_error` is cleared only by `reset`.

## Timing
- Forwarding selects, enables and flushes are combinational from the inputs and the current state, giving a same-cycle response. They are driven by logic only, with no path from outputs back to inputs.
- The state, `wait_cnt`, `mem_error` and both counters are registered. Counters reflect an event one cycle after it occurs.
- **Reset:**
  - State returns to RUN; `wait_cnt`, `mem_error`, `stall_cycles` and `flush_count` become 0.
  - While `reset` is high, all enables are forced to 1 and all flushes to 0.
- **Reset during MEM_WAIT:** the next state is RUN, and `mem_error` is unchanged from its reset value of 0.
- **Freeze latency:** a one-cycle access (ack in the request cycle) adds 0 stall cycles. An ack N cycles after the request adds N stall cycles.

## Structure
- `hazard_pkg` contains:
  - `fwd_sel_e` (FWD_REG=0, FWD_WB=1, FWD_MEM=2);
  - `hz_state_e` (RUN, MEM_WAIT);
  - the width constant for register indices (5).
- Sub-module `forward_unit`: combinational and instantiated once per operand. Inputs are rs, mem_rd, mem_reg_write, wb_rd and wb_reg_write; output is a `fwd_sel_e`.
- The FSM, the counters and the enable/flush decode stay in the top module.

## Test plan
- **Forwarding priority:** `ex_rs1`=5, `mem_rd`=5, `wb_rd`=5, both write-enables 1 -> `r1_solve`=2. Then `mem_rd`=0 -> `r1_solve`=1. Then `ex_rs1`=0 with all matching 0 -> `r1_solve`=0.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=7, `id_rs2`=7 -> `en_fetch`=0, `en_decode`=0, `flush_execute`=1. `stall_cycles` reads 1 on the next cycle.
- **Branch vs load-use:** `pc_src`=1 together with the load-use condition -> all enables 1, both flushes 1. `flush_count` increments and `stall_cycles` does not.
- **Memory freeze:** `dmem_req`=1 with the ack arriving 3 cycles later -> enables are 0 for 3 cycles, then 1 on the ack cycle. `stall_cycles` reads 3, and `pc_src` pulses during the wait are ignored.
- **Timeout:** `TIMEOUT`=4, `dmem_req` held with no ack -> `mem_error` reads 1 after the 4th wait cycle and the state returns to RUN. `mem_error` stays 1 until `reset`.
- **Saturation:** `CNT_W`=4 with 20 stall cycles -> `stall_cycles` reads 15. `cnt_clear` -> 0 on the next cycle.
